// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised SRAM model with byte-lane masked writes,
// power-on clear sweep, first-violation protocol checker and saturating access counters.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          INIT_ZERO   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic [31:0] o_dmem_rdata,
    output logic        o_init_busy,
    output logic        o_err_valid,
    output logic [1:0]  o_err_code,
    output logic [31:0] o_err_addr,
    output logic [31:0] o_rd_count,
    output logic [31:0] o_wr_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LANES = 4;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] clr_idx_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic [31:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] widx;
    logic             active;
    logic             viol;
    logic [1:0]       viol_code;
    logic             rd_ok;
    logic             wr_ok;
    logic [31:0]      rd_word;
    logic [31:0]      wr_word;

    // State register and sweep index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= INIT_ZERO ? ST_CLEAR : ST_READY;
            clr_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_idx_q <= clr_idx_q + IDX_W'(1);
            end
        end
    end

    // Next state: leave CLEAR once the last word has been swept
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
            state_d = ST_READY;
        end
    end

    assign o_init_busy = (state_q == ST_CLEAR);

    // Address decode, violation priority and lane merge
    always_comb begin
        off       = i_dmem_addr - BASE_ADDR;
        in_range  = (i_dmem_addr >= BASE_ADDR) && ({2'b00, off[31:2]} < DEPTH_WORDS);
        widx      = off[IDX_W+1:2];
        active    = !i_rst && (state_q == ST_READY) && (i_dmem_ren || i_dmem_wen);
        viol      = 1'b0;
        viol_code = 2'd0;
        if (active) begin
            viol = 1'b1;
            // BASE_ADDR is word aligned, so off[1:0] equals the address low bits
            if (i_dmem_ren && i_dmem_wen) begin
                viol_code = 2'd1;
            end else if (off[1:0] != 2'b00) begin
                viol_code = 2'd2;
            end else if (!in_range) begin
                viol_code = 2'd3;
            end else if (i_dmem_mask == 4'b0000) begin
                viol_code = 2'd0;
            end else begin
                viol = 1'b0;
            end
        end
        rd_ok        = active && !viol && i_dmem_ren;
        wr_ok        = active && !viol && i_dmem_wen;
        rd_word      = mem[widx];
        wr_word      = rd_word;
        o_dmem_rdata = '0;
        for (int n = 0; n < LANES; n++) begin
            if (i_dmem_mask[n]) begin
                wr_word[8*n +: 8] = i_dmem_wdata[8*n +: 8];
                if (rd_ok) begin
                    o_dmem_rdata[8*n +: 8] = rd_word[8*n +: 8];
                end
            end
        end
    end

    // Array: sweep clear has the port to itself while busy
    always_ff @(posedge i_clk) begin
        if (state_q == ST_CLEAR && !i_rst) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_ok) begin
            mem[widx] <= wr_word;
        end
    end

    // Sticky first-violation record and saturating counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err_valid <= 1'b0;
            o_err_code  <= 2'd0;
            o_err_addr  <= '0;
            o_rd_count  <= '0;
            o_wr_count  <= '0;
        end else begin
            if (viol && !o_err_valid) begin
                o_err_valid <= 1'b1;
                o_err_code  <= viol_code;
                o_err_addr  <= i_dmem_addr;
            end
            if (rd_ok && o_rd_count != 32'hFFFF_FFFF) begin
                o_rd_count <= o_rd_count + 32'd1;
            end
            if (wr_ok && o_wr_count != 32'hFFFF_FFFF) begin
                o_wr_count <= o_wr_count + 32'd1;
            end
        end
    end

endmodule
